// File: rtl/mod_counter_pkg.sv
// mod_counter_pkg: shared clock/calendar field constants and compare helper
package mod_counter_pkg;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HR24_MAX = 23;
    localparam int DAY_MIN  = 1;
    localparam int DAY_MAX  = 31;
    localparam int MON_MAX  = 12;
    localparam int SEC_W    = 6;
    localparam int MIN_W    = 6;
    localparam int HR_W     = 5;
    localparam int DAY_W    = 5;
    localparam int MON_W    = 4;

    // Unsigned a < b via the borrow of a 17-bit subtraction; avoids a constant
    // compare when b is a zero-valued parameter.
    function automatic logic below(input logic [16:0] a, input logic [16:0] b);
        logic [16:0] d;
        d = a - b;
        return d[16];
    endfunction

endpackage

// File: rtl/mod_counter_limit_sel.sv
// mod_counter_limit_sel: effective upper limit, out-of-range flag and terminal compares
//   count_i  : current count
//   max_in_i : run-time upper limit (used only when DYN_MAX=1)
//   down_i   : direction, 1 = down
//   lim_o    : effective limit, never below MIN_VAL
//   over_o   : count is above the effective limit
//   term_o   : count equals the terminal value for the direction
//   at_end_o : count at or beyond the terminal value (wrap condition)
module mod_counter_limit_sel import mod_counter_pkg::*; #(
    parameter int WIDTH   = SEC_W,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = SEC_MAX,
    parameter int DYN_MAX = 0
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic [WIDTH-1:0] max_in_i,
    input  logic             down_i,
    output logic [WIDTH-1:0] lim_o,
    output logic             over_o,
    output logic             term_o,
    output logic             at_end_o
);

    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] cap;

    always_comb begin
        cap      = (DYN_MAX != 0 && max_in_i < MAX_V) ? max_in_i : MAX_V;
        lim_o    = below(17'(cap), 17'(MIN_V)) ? MIN_V : cap;
        over_o   = count_i > lim_o;
        term_o   = down_i ? count_i == MIN_V : count_i == lim_o;
        // >= rather than == so a tick while above a freshly dropped limit still wraps
        at_end_o = down_i ? count_i <= MIN_V : count_i >= lim_o;
    end

endmodule

// File: rtl/mod_counter.sv
// mod_counter: up/down modulo counter over [MIN_VAL, lim] with load, clamp and carry
//   clk       : rising-edge clock
//   clear     : synchronous active-high reset
//   enable    : gates databus
//   load/data : parallel load, clamped into range
//   tick_in   : count qualifier from the previous stage
//   down      : 0 = up, 1 = down
//   max_in    : run-time upper limit (DYN_MAX=1)
//   count     : registered value
//   databus   : count when enable, else zero
//   term      : count at terminal value for the direction
//   carry_out : tick_in at terminal, ripples to the next stage
//   load_err  : one-cycle pulse after a clamped load
module mod_counter import mod_counter_pkg::*; #(
    parameter int WIDTH   = SEC_W,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = SEC_MAX,
    parameter int DYN_MAX = 0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             tick_in,
    input  logic             down,
    input  logic [WIDTH-1:0] max_in,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] databus,
    output logic             term,
    output logic             carry_out,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_VAL);

    logic [WIDTH-1:0] count_q, count_d, lim, ld_val;
    logic             err_q, err_d, over, at_end, data_hi, data_lo;

    mod_counter_limit_sel #(
        .WIDTH(WIDTH), .MIN_VAL(MIN_VAL), .MAX_VAL(MAX_VAL), .DYN_MAX(DYN_MAX)
    ) u_lim (
        .count_i(count_q), .max_in_i(max_in), .down_i(down),
        .lim_o(lim), .over_o(over), .term_o(term), .at_end_o(at_end)
    );

    always_comb begin
        data_hi = data > lim;
        data_lo = below(17'(data), 17'(MIN_V));
        ld_val  = data_hi ? lim : data_lo ? MIN_V : data;
        count_d = load    ? ld_val :
                  tick_in ? (at_end ? (down ? lim : MIN_V)
                                    : (down ? count_q - WIDTH'(1) : count_q + WIDTH'(1))) :
                  over    ? lim : count_q;
        err_d   = load & (data_hi | data_lo);
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            count_q <= MIN_V;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign count     = count_q;
    assign databus   = {WIDTH{enable}} & count_q;
    assign carry_out = tick_in & at_end;
    assign load_err  = err_q;

endmodule
